// File: rtl/vend_pkg.sv
// Shared types and constants for the vending front end: coin identities,
// cent values and the coin arbiter state encoding.
package vend_pkg;

  localparam int VALUE_W = 6;

  localparam logic [VALUE_W-1:0] CENTS_N = 6'd5;
  localparam logic [VALUE_W-1:0] CENTS_D = 6'd10;
  localparam logic [VALUE_W-1:0] CENTS_Q = 6'd25;

  typedef enum logic [1:0] {
    COIN_NONE,
    COIN_N,
    COIN_D,
    COIN_Q
  } coin_e;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_PULSE,
    ARB_GAP
  } arb_state_e;

  function automatic logic [VALUE_W-1:0] coin_cents(input coin_e coin);
    logic [VALUE_W-1:0] cents;
    cents = '0;
    case (coin)
      COIN_N:  cents = CENTS_N;
      COIN_D:  cents = CENTS_D;
      COIN_Q:  cents = CENTS_Q;
      default: cents = '0;
    endcase
    return cents;
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// One coin-sensor channel: 2-FF synchroniser, stability-count debouncer and
// a rising-edge detect on the debounced level.
module coin_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic rise
);

  localparam logic [7:0] LAST_COUNT = 8'(DEBOUNCE_CYCLES - 1);

  logic       sync_a;
  logic       sync_b;
  logic       level;
  logic       level_q;
  logic [7:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a  <= 1'b0;
      sync_b  <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      count   <= '0;
    end else begin
      sync_a  <= raw;
      sync_b  <= sync_a;
      level_q <= level;
      // The edge that would make the count reach DEBOUNCE_CYCLES flips the level.
      if (sync_b == level) begin
        count <= '0;
      end else if (count == LAST_COUNT) begin
        level <= ~level;
        count <= '0;
      end else begin
        count <= count + 8'd1;
      end
    end
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/coin_conditioner.sv
// Coin front end: three debounced sensors feed an IDLE/PULSE/GAP arbiter that
// emits exclusive one-cycle N/D/Q/Reject pulses. Define COIN_COUNT_EN to add
// the CoinCount accepted-coin counter port.
module coin_conditioner
  import vend_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               NIn,
  input  logic               DIn,
  input  logic               QIn,
  input  logic               Lock,
  output logic               N,
  output logic               D,
  output logic               Q,
  output logic               Reject,
  output logic [VALUE_W-1:0] Value,
  output arb_state_e         ArbState
`ifdef COIN_COUNT_EN
  ,
  output logic [7:0]         CoinCount
`endif
);

  logic [2:0] rise;
  logic [2:0] pend;
  logic [2:0] req;
  logic       multi;
  coin_e      sel;
  arb_state_e state;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_nickel (
    .clk(Clk), .rst_n(Rst_n), .raw(NIn), .rise(rise[0])
  );
  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dime (
    .clk(Clk), .rst_n(Rst_n), .raw(DIn), .rise(rise[1])
  );
  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_quarter (
    .clk(Clk), .rst_n(Rst_n), .raw(QIn), .rise(rise[2])
  );

  // Requests seen in IDLE: fresh rises plus anything parked during PULSE/GAP.
  assign req   = rise | pend;
  assign multi = (req & (req - 3'd1)) != 3'd0;

  always_comb begin
    sel = COIN_NONE;
    case (req)
      3'b001:  sel = COIN_N;
      3'b010:  sel = COIN_D;
      3'b100:  sel = COIN_Q;
      default: sel = COIN_NONE;
    endcase
  end

  // N/D/Q/Reject are single-cycle strobes with no back-pressure: the consumer
  // must take them in the cycle they are high, and at most one is high at once.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= ARB_IDLE;
      pend      <= '0;
      N         <= 1'b0;
      D         <= 1'b0;
      Q         <= 1'b0;
      Reject    <= 1'b0;
      Value     <= '0;
`ifdef COIN_COUNT_EN
      CoinCount <= '0;
`endif
    end else begin
      N      <= 1'b0;
      D      <= 1'b0;
      Q      <= 1'b0;
      Reject <= 1'b0;
      case (state)
        ARB_IDLE: begin
          pend <= '0;
          if (req != 3'd0) begin
            if (multi || Lock) begin
              Reject <= 1'b1;
            end else begin
              N     <= (sel == COIN_N);
              D     <= (sel == COIN_D);
              Q     <= (sel == COIN_Q);
              Value <= coin_cents(sel);
              state <= ARB_PULSE;
`ifdef COIN_COUNT_EN
              CoinCount <= CoinCount + 8'd1;
`endif
            end
          end
        end
        ARB_PULSE: begin
          pend  <= pend | rise;
          state <= ARB_GAP;
        end
        ARB_GAP: begin
          pend  <= pend | rise;
          state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign ArbState = state;

endmodule

// File: tb/tb_coin_conditioner.sv
// Scoreboard bench for coin_conditioner with DEBOUNCE_CYCLES=4; build with
// COIN_COUNT_EN defined to also exercise the CoinCount wrap.
module tb_coin_conditioner;
  import vend_pkg::*;

  localparam int DB = 4;
  localparam int LAT = DB + 2;

  logic               Clk = 1'b0;
  logic               Rst_n = 1'b0;
  logic               NIn = 1'b0;
  logic               DIn = 1'b0;
  logic               QIn = 1'b0;
  logic               Lock = 1'b0;
  logic               N, D, Q, Reject;
  logic [VALUE_W-1:0] Value;
  arb_state_e         ArbState;
`ifdef COIN_COUNT_EN
  logic [7:0]         CoinCount;
`endif

  coin_conditioner #(.DEBOUNCE_CYCLES(DB)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .NIn(NIn), .DIn(DIn), .QIn(QIn), .Lock(Lock),
    .N(N), .D(D), .Q(Q), .Reject(Reject), .Value(Value), .ArbState(ArbState)
`ifdef COIN_COUNT_EN
    , .CoinCount(CoinCount)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  logic [5:0]  model_value = '0;
  logic [7:0]  model_count = '0;

  // Entry = {pad, cycle, {N,D,Q,Reject}, Value}
  task automatic push_exp(input int c, input logic [3:0] outs, input logic [5:0] v);
    exp_q.push_back({6'd0, 16'(c), outs, v});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge Clk) begin : monitor
    logic [31:0] act_w;
    logic [31:0] exp_w;
    if (Rst_n && (N || D || Q || Reject)) begin
      act_w = {6'd0, 16'(cyc), N, D, Q, Reject, Value};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse: cyc=%0d NDQR=%b%b%b%b Value=%0d, none expected",
                 cyc, N, D, Q, Reject, Value);
      end else begin
        exp_w = exp_q.pop_front();
        if (act_w !== exp_w) begin
          n_bad++;
          $display("FAIL pulse: got cyc=%0d NDQR=%b Value=%0d expected cyc=%0d NDQR=%b Value=%0d",
                   act_w[25:10], act_w[9:6], act_w[5:0], exp_w[25:10], exp_w[9:6], exp_w[5:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Press the given {Q,D,N} sensors together, hold them, then release.
  task automatic coin(input logic [2:0] ch, input logic [3:0] outs, input logic [5:0] v);
    int t;
    @(negedge Clk);
    {QIn, DIn, NIn} = ch;
    t = cyc + 1;
    push_exp(t + LAT, outs, v);
    wait_cycles(10);
    {QIn, DIn, NIn} = 3'b000;
    wait_cycles(10);
  endtask

  task automatic accept(input logic [2:0] ch);
    logic [3:0] outs;
    outs = (ch == 3'b001) ? 4'b1000 : (ch == 3'b010) ? 4'b0100 : 4'b0010;
    model_value = (ch == 3'b001) ? 6'd5 : (ch == 3'b010) ? 6'd10 : 6'd25;
    model_count = model_count + 8'd1;
    coin(ch, outs, model_value);
  endtask

  task automatic pulse_reset();
    @(negedge Clk);
    Rst_n = 1'b0;
    model_value = '0;
    model_count = '0;
    wait_cycles(2);
    Rst_n = 1'b1;
    wait_cycles(2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t;
    wait_cycles(3);
    check("reset_outs", {28'd0, N, D, Q, Reject}, 32'd0);
    check("reset_value", 32'(Value), 32'd0);
    check("reset_state", 32'(ArbState), 32'(ARB_IDLE));
`ifdef COIN_COUNT_EN
    check("reset_count", 32'(CoinCount), 32'd0);
`endif
    Rst_n = 1'b1;
    wait_cycles(2);

    // Single nickel: pulse at t+DB+2.
    accept(3'b001);

    // Bouncing quarter, never stable long enough.
    for (int i = 0; i < 10; i++) begin
      QIn = ~QIn;
      wait_cycles(2);
    end
    QIn = 1'b0;
    wait_cycles(12);
    check("glitch_value", 32'(Value), 32'd5);

    // Coincident nickel + dime.
    coin(3'b011, 4'b0001, model_value);
    check("coincident_value", 32'(Value), 32'd5);

    // Locked dime refused, then quarter accepted.
    Lock = 1'b1;
    coin(3'b010, 4'b0001, model_value);
    Lock = 1'b0;
    accept(3'b100);
    check("quarter_value", 32'(Value), 32'd25);

    // Dime rises one cycle after nickel: dime parked, issued 3 cycles later.
    @(negedge Clk);
    NIn = 1'b1;
    t = cyc + 1;
    wait_cycles(1);
    DIn = 1'b1;
    push_exp(t + LAT, 4'b1000, 6'd5);
    push_exp(t + LAT + 3, 4'b0100, 6'd10);
    model_value = 6'd10;
    model_count = model_count + 8'd2;
    wait_cycles(14);
    {NIn, DIn} = 2'b00;
    wait_cycles(12);
    check("pending_value", 32'(Value), 32'd10);
`ifdef COIN_COUNT_EN
    check("count_mid", 32'(CoinCount), 32'(model_count));
`endif

    // Reset during PULSE clears N at once; held sensor gives one fresh pulse.
    @(negedge Clk);
    NIn = 1'b1;
    t = cyc + 1;
    while (cyc < t + LAT - 1) @(negedge Clk);
    @(posedge Clk);
    #1;
    check("pulse_before_reset", {31'd0, N}, 32'd1);
    #1;
    Rst_n = 1'b0;
    #1;
    check("reset_mid_outs", {28'd0, N, D, Q, Reject}, 32'd0);
    check("reset_mid_value", 32'(Value), 32'd0);
    check("reset_mid_state", 32'(ArbState), 32'(ARB_IDLE));
    model_value = '0;
    model_count = '0;
    @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    t = cyc + 1;
    model_value = 6'd5;
    model_count = 8'd1;
    push_exp(t + LAT, 4'b1000, 6'd5);
    wait_cycles(12);
    NIn = 1'b0;
    wait_cycles(12);
`ifdef COIN_COUNT_EN
    check("count_after_reset", 32'(CoinCount), 32'd1);

    pulse_reset();
    for (int i = 0; i < 256; i++) begin
      accept((i % 3 == 0) ? 3'b001 : (i % 3 == 1) ? 3'b010 : 3'b100);
    end
    check("count_wrap", 32'(CoinCount), 32'(model_count));
    check("count_wrap_zero", 32'(CoinCount), 32'd0);
`endif

    wait_cycles(20);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
